// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced RUN/PAUSED/ADJUST mode controller emitting clock-enable pulses
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DIV_1HZ   = 100_000_000,
  parameter int DIV_2HZ   = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause,
  input  logic btn_reset,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic count_en,
  output logic adj_en,
  output logic adj_sel,
  output logic clr,
  output logic paused,
  output logic adjusting,
  output logic blink
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam int W1 = $clog2(DIV_1HZ);
  localparam int W2 = $clog2(DIV_2HZ);
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);
  localparam logic [W1-1:0] P1_MAX = W1'(DIV_1HZ - 1);
  localparam logic [W2-1:0] P2_MAX = W2'(DIV_2HZ - 1);
  if (DIV_1HZ < 2 || DIV_2HZ < 2 || DB_CYCLES < 2 || CLK_HZ < 1) begin : g_bad_param
    $error("stopwatch_ctrl: invalid parameter");
  end
  typedef enum logic [1:0] {RUN, PAUSED, ADJUST} state_t;
  state_t st_q, st_d, ret_q, ret_d;
  logic [3:0] s1_q, s2_q;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0] db_q, db_d, dbd_q, prs_q;
  logic adj_q, rp, pp, a2;
  logic [W1-1:0] p1_q, p1_d;
  logic [W2-1:0] p2_q, p2_d;
  always_comb begin
    db_d = db_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != db_q[i]) begin
        cnt_d[i] = (cnt_q[i] == DB_MAX) ? '0 : cnt_q[i] + 1'b1;
        db_d[i] = (cnt_q[i] == DB_MAX) ? s2_q[i] : db_q[i];
      end
    end
  end
  assign rp = prs_q[1];
  assign pp = prs_q[0];
  // a reset press masks both the adjust switch and the pause press for this cycle
  always_comb begin
    st_d = st_q;
    ret_d = ret_q;
    if (!rp && st_q == ADJUST && !adj_q) st_d = ret_q;
    else if (!rp && st_q != ADJUST && adj_q) begin
      st_d = ADJUST;
      ret_d = st_q;
    end else if (!rp && st_q != ADJUST && pp) st_d = (st_q == RUN) ? PAUSED : RUN;
  end
  assign a2 = !rp && st_q == ADJUST;
  assign p1_d = rp ? '0 : (st_q != RUN) ? p1_q : (p1_q == P1_MAX) ? '0 : p1_q + 1'b1;
  assign p2_d = (!a2 || st_d != ADJUST || p2_q == P2_MAX) ? '0 : p2_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      cnt_q <= '0;
      db_q <= '0;
      dbd_q <= '0;
      prs_q <= '0;
      adj_q <= 1'b0;
      st_q <= RUN;
      ret_q <= RUN;
      p1_q <= '0;
      p2_q <= '0;
      count_en <= 1'b0;
      adj_en <= 1'b0;
      clr <= 1'b0;
      paused <= 1'b0;
      adjusting <= 1'b0;
      blink <= 1'b0;
    end else begin
      s1_q <= {sw_sel, sw_adj, btn_reset, btn_pause};
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      db_q <= db_d;
      dbd_q <= db_q;
      prs_q <= db_q & ~dbd_q;
      adj_q <= s2_q[2];
      st_q <= st_d;
      ret_q <= ret_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      count_en <= !rp && st_q == RUN && p1_q == P1_MAX;
      adj_en <= a2 && p2_q == P2_MAX;
      clr <= rp;
      paused <= st_d == PAUSED;
      adjusting <= st_d == ADJUST;
      blink <= !rp && st_d == ADJUST && (blink ^ (a2 && p2_q == P2_MAX));
    end
  end
  assign adj_sel = s2_q[3];
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table-driven directed check of stopwatch_ctrl with small divisors
module tb_stopwatch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_pause = 1'b0, btn_reset = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic count_en, adj_en, adj_sel, clr, paused, adjusting, blink;
  logic [6:0] outs;
  int cyc, total, passed, n;
  typedef struct {
    int t;
    logic rn;
    logic [3:0] in;
    logic [6:0] exp;
  } vec_t;
  vec_t q[$];
  stopwatch_ctrl #(.DIV_1HZ(10), .DIV_2HZ(4), .DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_reset(btn_reset),
    .sw_adj(sw_adj), .sw_sel(sw_sel), .count_en(count_en), .adj_en(adj_en),
    .adj_sel(adj_sel), .clr(clr), .paused(paused), .adjusting(adjusting), .blink(blink)
  );
  always #5 clk = ~clk;
  assign outs = {count_en, adj_en, adj_sel, clr, paused, adjusting, blink};
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (ce,ae,sel,clr,pau,adj,blink)", name, act, exp);
  endtask
  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic add(input int t, input logic rn, input logic [3:0] in, input logic [6:0] exp);
    q.push_back('{t, rn, in, exp});
  endtask
  task automatic wait_clr(output int cnt);
    cnt = 0;
    while (clr !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask
  initial begin
    // inputs packed {sw_sel, sw_adj, btn_reset, btn_pause}; outputs as in outs
    add(0, 1, 4'b0000, 7'b0000000);   add(9, 1, 4'b0000, 7'b0000000);
    add(10, 1, 4'b0000, 7'b1000000);  add(11, 1, 4'b0000, 7'b0000000);
    add(20, 1, 4'b0000, 7'b1000000);  add(30, 1, 4'b0000, 7'b1000000);
    add(38, 1, 4'b0001, 7'b0000000);  add(40, 1, 4'b0001, 7'b1000000);
    add(45, 1, 4'b0001, 7'b0000000);  add(46, 1, 4'b0001, 7'b0000100);
    add(48, 1, 4'b0000, 7'b0000100);  add(60, 1, 4'b0001, 7'b0000100);
    add(66, 1, 4'b0000, 7'b0000100);  add(67, 1, 4'b0000, 7'b0000100);
    add(68, 1, 4'b0000, 7'b0000000);  add(71, 1, 4'b0000, 7'b0000000);
    add(72, 1, 4'b0000, 7'b1000000);  add(82, 1, 4'b0000, 7'b1000000);
    add(84, 1, 4'b0001, 7'b0000000);  add(86, 1, 4'b0000, 7'b0000000);
    add(92, 1, 4'b0000, 7'b1000000);  add(93, 1, 4'b0000, 7'b0000000);
    add(94, 1, 4'b0001, 7'b0000000);  add(100, 1, 4'b0000, 7'b0000000);
    add(101, 1, 4'b0000, 7'b0000000); add(102, 1, 4'b0000, 7'b1000100);
    add(103, 1, 4'b0000, 7'b0000100); add(110, 1, 4'b0100, 7'b0000100);
    add(113, 1, 4'b0100, 7'b0000100); add(114, 1, 4'b0100, 7'b0000010);
    add(117, 1, 4'b0100, 7'b0000010); add(118, 1, 4'b0100, 7'b0100011);
    add(119, 1, 4'b0100, 7'b0000011); add(120, 1, 4'b0101, 7'b0000011);
    add(122, 1, 4'b0101, 7'b0100010); add(126, 1, 4'b0100, 7'b0100011);
    add(128, 1, 4'b0100, 7'b0000011); add(130, 1, 4'b0100, 7'b0100010);
    add(132, 1, 4'b0000, 7'b0000010); add(134, 1, 4'b0000, 7'b0100011);
    add(135, 1, 4'b0000, 7'b0000011); add(136, 1, 4'b1000, 7'b0000100);
    add(137, 1, 4'b1000, 7'b0000100); add(138, 1, 4'b1000, 7'b0010100);
    add(140, 1, 4'b0000, 7'b0010100); add(141, 1, 4'b0000, 7'b0010100);
    add(142, 1, 4'b0000, 7'b0000100); add(144, 1, 4'b0001, 7'b0000100);
    add(150, 1, 4'b0000, 7'b0000100); add(151, 1, 4'b0000, 7'b0000100);
    add(152, 1, 4'b0000, 7'b0000000); add(161, 1, 4'b0000, 7'b0000000);
    add(162, 1, 4'b0000, 7'b1000000); add(164, 1, 4'b0011, 7'b0000000);
    add(170, 1, 4'b0000, 7'b0000000); add(171, 1, 4'b0000, 7'b0000000);
    add(172, 1, 4'b0000, 7'b0001000); add(173, 1, 4'b0000, 7'b0000000);
    add(181, 1, 4'b0000, 7'b0000000); add(182, 1, 4'b0000, 7'b1000000);
    add(184, 1, 4'b0100, 7'b0000000); add(187, 1, 4'b0100, 7'b0000000);
    add(188, 1, 4'b0100, 7'b0000010); add(192, 1, 4'b0100, 7'b0100011);
    add(193, 0, 4'b0000, 7'b0000011); add(194, 1, 4'b0000, 7'b0000000);
    add(203, 1, 4'b0000, 7'b0000000); add(204, 1, 4'b0000, 7'b1000000);
    tick();
    tick();
    cyc = 0;
    foreach (q[i]) begin
      while (cyc < q[i].t) tick();
      chk($sformatf("vec%0d_t%0d", i, q[i].t), outs, q[i].exp);
      rst_n = q[i].rn;
      {sw_sel, sw_adj, btn_reset, btn_pause} = q[i].in;
    end
    btn_reset = 1'b1;
    wait_clr(n);
    chk_int("reset_btn_latency", n, 8);
    chk("reset_btn_outputs", outs, 7'b0001000);
    btn_reset = 1'b0;
    repeat (10) tick();
    btn_reset = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_debounce_outputs", outs, 7'b0000000);
    rst_n = 1'b1;
    wait_clr(n);
    chk_int("rst_mid_debounce_latency", n, 8);
    chk("rst_mid_debounce_clr", outs, 7'b0001000);
    btn_reset = 1'b0;
    repeat (8) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
